// File: rtl/mult_eval_pkg.sv
// Shared types and width helpers for the multiplier sweep checker.
package mult_eval_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StFin
   } state_e;

   // Number of (A, B) pairs in one exhaustive sweep.
   function automatic int unsigned sweep_len(input int unsigned width);
      return 32'd1 << (2 * width);
   endfunction

   // Product / sweep index width.
   function automatic int unsigned prod_w(input int unsigned width);
      return 2 * width;
   endfunction

   // Mismatch counter width; must hold the full sweep length.
   function automatic int unsigned cnt_w(input int unsigned width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/mult_eval_accum.sv
// Compare stage: golden product, absolute error and result accumulation.
module mult_eval_accum
   import mult_eval_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       valid,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic [prod_w(WIDTH)-1:0]   p,
   output logic [cnt_w(WIDTH)-1:0]    err_count,
   output logic                       first_err_valid,
   output logic [WIDTH-1:0]           first_err_a,
   output logic [WIDTH-1:0]           first_err_b,
   output logic [prod_w(WIDTH)-1:0]   first_err_p,
   output logic [prod_w(WIDTH)-1:0]   max_abs_err
);

   localparam int unsigned PW = prod_w(WIDTH);
   localparam int unsigned CW = cnt_w(WIDTH);

   logic [PW-1:0] golden;
   logic [PW-1:0] diff;
   logic          mismatch;

   // Exact product and unsigned absolute error of the captured sample.
   always_comb begin
      golden   = PW'(a) * PW'(b);
      diff     = (p >= golden) ? (p - golden) : (golden - p);
      mismatch = (p != golden);
   end

   // Result registers: cleared on sweep start, updated on each mismatching sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         first_err_p     <= '0;
         max_abs_err     <= '0;
      end else if (clear) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         first_err_p     <= '0;
         max_abs_err     <= '0;
      end else if (valid && mismatch) begin
         err_count <= err_count + CW'(1);
         if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_a     <= a;
            first_err_b     <= b;
            first_err_p     <= p;
         end
         if (diff > max_abs_err) begin
            max_abs_err <= diff;
         end
      end
   end

endmodule

// File: rtl/mult_sweep_checker.sv
// Exhaustive operand sweeper for a combinational multiplier, with product checking.
module mult_sweep_checker
   import mult_eval_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic [WIDTH-1:0]           dut_a,
   output logic [WIDTH-1:0]           dut_b,
   input  logic [prod_w(WIDTH)-1:0]   dut_p,
   output logic                       busy,
   output logic                       done,
   output logic [cnt_w(WIDTH)-1:0]    err_count,
   output logic                       first_err_valid,
   output logic [WIDTH-1:0]           first_err_a,
   output logic [WIDTH-1:0]           first_err_b,
   output logic [prod_w(WIDTH)-1:0]   first_err_p,
   output logic [prod_w(WIDTH)-1:0]   max_abs_err
);

   localparam int unsigned   PW       = prod_w(WIDTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(sweep_len(WIDTH) - 1);

   state_e          state_q, state_d;
   logic [PW-1:0]   idx_q, idx_d;
   logic            clear;
   logic            s1_valid_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   logic [PW-1:0]   s1_p_q;

   // Next state and index; idx doubles as the operand register and is 0 outside RUN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               idx_d   = '0;
               clear   = 1'b1;
            end
         end
         StRun: begin
            if (idx_q == LAST_IDX) begin
               state_d = StDrain;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + PW'(1);
            end
         end
         StDrain: state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM state and sweep index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Stage 1: capture the presented pair and its returned product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_p_q     <= '0;
      end else begin
         s1_valid_q <= (state_q == StRun);
         s1_a_q     <= dut_a;
         s1_b_q     <= dut_b;
         s1_p_q     <= dut_p;
      end
   end

   // B varies fastest; DRAIN covers the two pipeline stages behind the last pair.
   always_comb begin
      dut_a = idx_q[PW-1:WIDTH];
      dut_b = idx_q[WIDTH-1:0];
      busy  = (state_q == StRun) || (state_q == StDrain);
      done  = (state_q == StFin);
   end

   mult_eval_accum #(
      .WIDTH (WIDTH)
   ) u_accum (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (clear),
      .valid           (s1_valid_q),
      .a               (s1_a_q),
      .b               (s1_b_q),
      .p               (s1_p_q),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_a     (first_err_a),
      .first_err_b     (first_err_b),
      .first_err_p     (first_err_p),
      .max_abs_err     (max_abs_err)
   );

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Scoreboard bench: a behavioural multiplier LUT feeds the checker; a monitor
// compares each done pulse against results computed from the LUT contents.
module tb_mult_sweep_checker;

   localparam int unsigned W = 4;
   localparam int          N = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] dut_a, dut_b;
   logic [7:0] dut_p;
   logic       busy, done;
   logic [8:0] err_count;
   logic       first_err_valid;
   logic [3:0] first_err_a, first_err_b;
   logic [7:0] first_err_p, max_abs_err;

   logic [7:0] lut [N];

   typedef struct {
      int err;
      int fv;
      int fa;
      int fb;
      int fp;
      int maxe;
      int e0;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier under test: lookup of the product table.
   assign dut_p = lut[{dut_a, dut_b}];

   mult_sweep_checker #(
      .WIDTH (W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .dut_a           (dut_a),
      .dut_b           (dut_b),
      .dut_p           (dut_p),
      .busy            (busy),
      .done            (done),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_a     (first_err_a),
      .first_err_b     (first_err_b),
      .first_err_p     (first_err_p),
      .max_abs_err     (max_abs_err)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // 0 exact, 1 P[0] stuck-0, 2 P[7] stuck-0, 3 sparse random corruption, 4 random stuck bit
   task automatic load_lut(input int mode);
      int k;
      int v;
      k = $urandom_range(0, 7);
      v = $urandom_range(0, 1);
      for (int i = 0; i < N; i++) begin
         lut[i] = 8'((i / 16) * (i % 16));
         case (mode)
            1: lut[i][0] = 1'b0;
            2: lut[i][7] = 1'b0;
            3: if ($urandom_range(0, 15) == 0) lut[i] = 8'($urandom_range(0, 255));
            4: lut[i][k] = v[0];
            default: ;
         endcase
      end
   endtask

   // Reference: walk every pair in sweep order with plain arithmetic.
   function automatic exp_t model();
      exp_t e;
      e.err = 0; e.fv = 0; e.fa = 0; e.fb = 0; e.fp = 0; e.maxe = 0; e.e0 = 0;
      for (int i = 0; i < N; i++) begin
         int a, b, g, p, d;
         a = i / 16;
         b = i % 16;
         g = a * b;
         p = int'(lut[i]);
         if (p != g) begin
            e.err++;
            if (e.fv == 0) begin
               e.fv = 1; e.fa = a; e.fb = b; e.fp = p;
            end
            d = (p > g) ? p - g : g - p;
            if (d > e.maxe) e.maxe = d;
         end
      end
      return e;
   endfunction

   task automatic start_sweep();
      exp_t e;
      e = model();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.e0 = cyc;
      exp_q.push_back(e);
      check("busy_after_start", int'(busy), 1);
   endtask

   // Wait for done with a bound; optionally pulse start during the done cycle.
   task automatic wait_done(input bit poke_fin);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", int'(seen), 1);
      if (poke_fin && seen) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      int agg;
      agg = int'(busy) + int'(done) + int'(err_count) + int'(first_err_valid) +
            int'(first_err_a) + int'(first_err_b) + int'(first_err_p) +
            int'(max_abs_err) + int'(dut_a) + int'(dut_b);
      check(tag, agg, 0);
   endtask

   // Monitor: operand order while a sweep is tracked, result compare on done.
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0) begin
            int k;
            k = cyc - exp_q[0].e0;
            if (k >= 0 && k < N) begin
               check("dut_a_order", int'(dut_a), k / 16);
               check("dut_b_order", int'(dut_b), k % 16);
            end else if (k >= N) begin
               check("operands_idle", int'({dut_a, dut_b}), 0);
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done=1 expected no pending sweep (t=%0t)",
                        $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("latency", cyc - mon_e.e0, N + 1);
               check("busy_at_done", int'(busy), 0);
               check("err_count", int'(err_count), mon_e.err);
               check("first_err_valid", int'(first_err_valid), mon_e.fv);
               check("first_err_a", int'(first_err_a), mon_e.fa);
               check("first_err_b", int'(first_err_b), mon_e.fb);
               check("first_err_p", int'(first_err_p), mon_e.fp);
               check("max_abs_err", int'(max_abs_err), mon_e.maxe);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      load_lut(0);
      #12;
      check_all_zero("reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;

      // Exact, P[0] stuck, P[7] stuck.
      for (int m = 0; m < 3; m++) begin
         load_lut(m);
         start_sweep();
         wait_done(1'b0);
      end

      // Randomised faulty multipliers with random idle gaps.
      for (int r = 0; r < 4; r++) begin
         load_lut((r % 2 == 0) ? 3 : 4);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         start_sweep();
         wait_done(1'b0);
      end

      // Extra start pulses in RUN and in the done cycle are ignored.
      load_lut(1);
      start_sweep();
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b1);
      repeat (20) @(negedge clk);
      check("no_restart_busy", int'(busy), 0);

      // Asynchronous reset mid-sweep, then a clean sweep.
      load_lut(1);
      start_sweep();
      repeat (100) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_all_zero("midsweep_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("post_reset_idle", int'(busy), 0);
      load_lut(0);
      start_sweep();
      wait_done(1'b0);

      // Back-to-back: faulty then exact, results must clear on start.
      load_lut(1);
      start_sweep();
      wait_done(1'b0);
      load_lut(0);
      start_sweep();
      wait_done(1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
